exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning cycles flush stays high after the redirect handshake.
REQ-002 SHALL have port clk  in  1  the single clock, rising-edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port wb_valid  in  1  writeback stage holds an instruction.
REQ-005 SHALL have port wb_pc  in  32  PC of the writeback instruction.
REQ-006 SHALL have port wb_exc  in  5  raised exceptions: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE.
REQ-007 SHALL have port wb_ertn  in  1  the writeback instruction is ertn.
REQ-008 SHALL have port wb_ready  out  1  controller accepts the writeback instruction this cycle.
REQ-009 SHALL have port wb_commit  out  1  pulse: the instruction retired normally.
REQ-010 SHALL have ports ext_int, timer_int  in  1 each  raw interrupt lines.
REQ-011 SHALL have port int_enable  in  1  global interrupt enable, CRMD.IE.
REQ-012 SHALL have port ex_entry  in  32  exception entry address.
REQ-013 SHALL have port era_addr  in  32  exception return address.
REQ-014 SHALL have port csr_ex  out  1  one-cycle trap-entry strobe to the CSR file.
REQ-015 SHALL have port csr_ecode  out  6  ecode for the trap entry.
REQ-016 SHALL have port csr_esubcode  out  10  esubcode for the trap entry.
REQ-017 SHALL have port csr_pc  out  32  ERA value for the trap entry.
REQ-018 SHALL have port csr_ertn  out  1  one-cycle ertn strobe.
REQ-019 SHALL have port flush  out  1  pipeline flush.
REQ-020 SHALL have ports redirect_valid  out  1  and redirect_pc  out  32  fetch redirect request.
REQ-021 SHALL have port redirect_ready  in  1  fetch accepts the redirect.

Function
REQ-022 SHALL implement FSM states IDLE, TRAP, REDIR, DRAIN; wb_ready = 1 only in IDLE.
REQ-023 SHALL synchronise ext_int through 2 flops; timer_int is used unsynchronised; int_pend = (ext_sync | timer_int) & int_enable.
REQ-024 SHALL, in IDLE with wb_valid=1, select the event by priority: int_pend > ADEF > INE > SYS > BRK > ALE > ertn > normal commit.
REQ-025 SHALL map ecodes: INT=0x00, ADEF=0x08, ALE=0x09, SYS=0x0B, BRK=0x0C, INE=0x0D; esubcode = 0 for all.
REQ-026 SHALL, on a normal commit, pulse wb_commit for 1 cycle and remain in IDLE.
REQ-027 SHALL, on an interrupt or exception, set csr_ex=1 for exactly the next cycle, with registered ecode/esubcode and csr_pc=wb_pc, then go to TRAP; wb_commit stays 0.
REQ-028 SHALL, on ertn without an exception, set csr_ertn=1 for exactly the next cycle, then go to TRAP.
REQ-029 SHALL, in TRAP (one cycle, CSR update visible), go to REDIR and latch redirect_pc = ex_entry for a trap, or era_addr for an ertn.
REQ-030 SHALL, in REDIR, hold redirect_valid=1, flush=1 and redirect_pc stable until redirect_ready=1; on that cycle go to DRAIN.
REQ-031 SHALL, in DRAIN, hold flush=1 for FLUSH_CYCLES cycles using a down-counter, then return to IDLE with flush=0.
REQ-032 SHALL ignore wb_valid, interrupts and ertn outside IDLE; an interrupt still pending is taken at the next IDLE instruction.
REQ-033 SHALL never take an interrupt when wb_valid=0.

Reset
REQ-034 SHALL, on reset assertion at any time including mid-sequence, go immediately to IDLE and drive 0 on csr_ex, csr_ertn, flush, redirect_valid, wb_commit, csr_ecode, csr_esubcode, csr_pc and redirect_pc, and clear the synchroniser and counter.
REQ-035 SHALL drive wb_ready=1 one clock after reset deasserts.

Verification
REQ-036 SHALL cover: wb_valid=1, wb_exc=5'b00100 (SYS), wb_pc=0x1c000100 -> next cycle csr_ex=1, ecode=0x0B, csr_pc=0x1c000100; redirect_pc=ex_entry.
REQ-037 SHALL cover: wb_exc=5'b10010 (INE+ALE) -> ecode=0x0D only.
REQ-038 SHALL cover: timer_int=1, int_enable=1, with wb_exc=ADEF in the same cycle -> ecode=0x00 (interrupt wins); with int_enable=0 -> ecode=0x08.
REQ-039 SHALL cover: wb_ertn=1, era_addr=0x1c000204 -> csr_ertn pulse, redirect_pc=0x1c000204; redirect_ready held 0 for 3 cycles keeps redirect_valid=1 and flush=1; after acceptance flush stays high 2 cycles.
REQ-040 SHALL cover: reset asserted in REDIR -> all outputs 0 asynchronously; wb_ready=1 one clock after release.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller at writeback: picks the highest-priority event,
// strobes the CSR file, then runs the fetch redirect and the pipeline flush.
module exc_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [4:0]  wb_exc,
    input  logic        wb_ertn,
    output logic        wb_ready,
    output logic        wb_commit,
    input  logic        ext_int,
    input  logic        timer_int,
    input  logic        int_enable,
    input  logic [31:0] ex_entry,
    input  logic [31:0] era_addr,
    output logic        csr_ex,
    output logic [5:0]  csr_ecode,
    output logic [9:0]  csr_esubcode,
    output logic [31:0] csr_pc,
    output logic        csr_ertn,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {IDLE, TRAP, REDIR, DRAIN} state_t;

    localparam int            CW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

    localparam logic [5:0] EC_INT  = 6'h00;
    localparam logic [5:0] EC_ADEF = 6'h08;
    localparam logic [5:0] EC_ALE  = 6'h09;
    localparam logic [5:0] EC_SYS  = 6'h0B;
    localparam logic [5:0] EC_BRK  = 6'h0C;
    localparam logic [5:0] EC_INE  = 6'h0D;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          ext_meta, ext_sync;
    logic          ready_q;
    logic          int_pend;
    logic          is_trap, is_ertn, accept;
    logic [5:0]    ecode;

    assign int_pend     = (ext_sync | timer_int) & int_enable;
    assign csr_esubcode = '0;

    // Fixed priority: interrupt first, then exceptions by bit order ADEF..ALE, then ertn.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        is_trap = 1'b1;
        ecode   = EC_INT;
        if (int_pend)       ecode = EC_INT;
        else if (wb_exc[0]) ecode = EC_ADEF;
        else if (wb_exc[1]) ecode = EC_INE;
        else if (wb_exc[2]) ecode = EC_SYS;
        else if (wb_exc[3]) ecode = EC_BRK;
        else if (wb_exc[4]) ecode = EC_ALE;
        else                is_trap = 1'b0;
    end

    assign is_ertn = !is_trap && wb_ertn;
    assign accept  = wb_ready && wb_valid;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        wb_ready       = (state == IDLE) && ready_q;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (is_trap || is_ertn)) state_next = TRAP;
            end
            TRAP: state_next = REDIR;
            REDIR: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                if (redirect_ready) begin
                    state_next = DRAIN;
                    cnt_next   = CNT_LOAD;
                end
            end
            DRAIN: begin
                flush = 1'b1;
                if (cnt == '0) state_next = IDLE;
                else           cnt_next   = cnt - CW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ext_meta <= 1'b0;
            ext_sync <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ext_meta <= ext_int;
            ext_sync <= ext_meta;
            ready_q  <= 1'b1;
        end
    end

    // CSR strobes are registered; the TRAP cycle is when the CSR file sees them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_ex      <= 1'b0;
            csr_ertn    <= 1'b0;
            wb_commit   <= 1'b0;
            csr_ecode   <= '0;
            csr_pc      <= '0;
            redirect_pc <= '0;
        end else begin
            csr_ex    <= accept && is_trap;
            csr_ertn  <= accept && is_ertn;
            wb_commit <= accept && !is_trap && !is_ertn;
            if (accept && is_trap) begin
                csr_ecode <= ecode;
                csr_pc    <= wb_pc;
            end
            if (state == TRAP) redirect_pc <= csr_ertn ? era_addr : ex_entry;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed corner cases plus randomized
// transactions checked against a transaction-level timeline model.
module tb_exc_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_ertn, wb_ready, wb_commit;
    logic [31:0] wb_pc, ex_entry, era_addr, csr_pc, redirect_pc;
    logic [4:0]  wb_exc;
    logic        ext_int, timer_int, int_enable;
    logic        csr_ex, csr_ertn, flush, redirect_valid, redirect_ready;
    logic [5:0]  csr_ecode;
    logic [9:0]  csr_esubcode;

    int n_checks = 0;
    int n_errors = 0;

    exc_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc), .wb_ertn(wb_ertn),
        .wb_ready(wb_ready), .wb_commit(wb_commit),
        .ext_int(ext_int), .timer_int(timer_int), .int_enable(int_enable),
        .ex_entry(ex_entry), .era_addr(era_addr),
        .csr_ex(csr_ex), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .csr_pc(csr_pc), .csr_ertn(csr_ertn), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef enum int {K_COMMIT, K_TRAP, K_ERTN} kind_t;

    // Reference: walk the priority list; exception bits are ordered ADEF,INE,SYS,BRK,ALE.
    function automatic void ref_event(input logic ip, input logic [4:0] exc, input logic ertn,
                                      output kind_t kind, output logic [5:0] code);
        int         order[5] = '{0, 1, 2, 3, 4};
        logic [5:0] codes[5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        kind = K_COMMIT;
        code = 6'h00;
        if (ip) begin
            kind = K_TRAP;
            return;
        end
        foreach (order[i]) begin
            if (exc[order[i]]) begin
                kind = K_TRAP;
                code = codes[i];
                return;
            end
        end
        if (ertn) kind = K_ERTN;
    endfunction

    // Idle gap with wb_valid=0: interrupts must not be taken, and ext_int settles through the synchroniser.
    task automatic gap(input logic ext_v);
        ext_int    = ext_v;
        wb_valid   = 1'b0;
        timer_int  = 1'($urandom_range(0, 1));
        int_enable = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("gap_no_ex", csr_ex, 1'b0);
            check("gap_no_commit", wb_commit, 1'b0);
        end
    endtask

    // One instruction presented in IDLE; caller guarantees ext_int has been stable for 2 cycles.
    task automatic run_txn(input logic [31:0] pc, input logic [4:0] exc, input logic ertn,
                           input logic tmr, input logic ie, input logic [31:0] entry,
                           input logic [31:0] era, input int dly);
        kind_t       kind;
        logic [5:0]  code;
        logic [31:0] exp_pc;
        ref_event((ext_int | tmr) & ie, exc, ertn, kind, code);
        exp_pc = (kind == K_ERTN) ? era : entry;

        check("ready_idle", wb_ready, 1'b1);
        wb_valid = 1'b1; wb_pc = pc; wb_exc = exc; wb_ertn = ertn;
        timer_int = tmr; int_enable = ie; ex_entry = entry; era_addr = era;
        redirect_ready = 1'b0;
        @(negedge clk);

        if (kind == K_COMMIT) begin
            check("commit_pulse", wb_commit, 1'b1);
            check("commit_no_ex", csr_ex, 1'b0);
            check("commit_no_ertn", csr_ertn, 1'b0);
            check("commit_ready", wb_ready, 1'b1);
            wb_valid = 1'b0;
            timer_int = 1'b0;
            @(negedge clk);
            check("commit_one_cycle", wb_commit, 1'b0);
            return;
        end

        check("trap_ex", csr_ex, kind == K_TRAP);
        check("trap_ertn", csr_ertn, kind == K_ERTN);
        check("trap_no_commit", wb_commit, 1'b0);
        check("trap_not_ready", wb_ready, 1'b0);
        check("trap_no_flush", flush, 1'b0);
        if (kind == K_TRAP) begin
            check("ecode", csr_ecode, code);
            check("esubcode", csr_esubcode, 10'd0);
            check("csr_pc", csr_pc, pc);
        end
        // Garbage while busy must be ignored.
        wb_exc = 5'($urandom); wb_ertn = 1'($urandom); timer_int = 1'b1; int_enable = 1'b1;
        @(negedge clk);
        check("redir_valid", redirect_valid, 1'b1);
        check("redir_flush", flush, 1'b1);
        check("redir_pc", redirect_pc, exp_pc);
        check("ex_one_cycle", csr_ex, 1'b0);
        check("ertn_one_cycle", csr_ertn, 1'b0);
        ex_entry = $urandom; era_addr = $urandom;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("stall_valid", redirect_valid, 1'b1);
            check("stall_flush", flush, 1'b1);
            check("stall_pc", redirect_pc, exp_pc);
        end
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        for (int i = 0; i < FC; i++) begin
            check("drain_flush", flush, 1'b1);
            check("drain_no_valid", redirect_valid, 1'b0);
            check("drain_not_ready", wb_ready, 1'b0);
            check("drain_no_ex", csr_ex, 1'b0);
            @(negedge clk);
        end
        check("done_flush", flush, 1'b0);
        check("done_ready", wb_ready, 1'b1);
        check("done_no_ex", csr_ex, 1'b0);
        wb_valid = 1'b0; timer_int = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ex"}, csr_ex, 1'b0);
        check({tag, "_ertn"}, csr_ertn, 1'b0);
        check({tag, "_flush"}, flush, 1'b0);
        check({tag, "_rvalid"}, redirect_valid, 1'b0);
        check({tag, "_commit"}, wb_commit, 1'b0);
        check({tag, "_ecode"}, csr_ecode, 6'd0);
        check({tag, "_esub"}, csr_esubcode, 10'd0);
        check({tag, "_csrpc"}, csr_pc, 32'd0);
        check({tag, "_rpc"}, redirect_pc, 32'd0);
        check({tag, "_ready"}, wb_ready, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        wb_valid = 0; wb_pc = 0; wb_exc = 0; wb_ertn = 0;
        ext_int = 0; timer_int = 0; int_enable = 0;
        ex_entry = 0; era_addr = 0; redirect_ready = 0;
        #1 check_all_zero("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check("ready_after_rst", wb_ready, 1'b1);
        @(negedge clk);

        // Directed corner cases.
        gap(1'b0);
        run_txn(32'h1c000100, 5'b00100, 1'b0, 1'b0, 1'b0, 32'h1c008000, 32'h0, 0);
        gap(1'b0);
        run_txn(32'h1c000110, 5'b10010, 1'b0, 1'b0, 1'b0, 32'h1c008000, 32'h0, 1);
        gap(1'b0);
        run_txn(32'h1c000120, 5'b00001, 1'b0, 1'b1, 1'b1, 32'h1c008040, 32'h0, 0);
        gap(1'b0);
        run_txn(32'h1c000130, 5'b00001, 1'b0, 1'b1, 1'b0, 32'h1c008040, 32'h0, 0);
        gap(1'b0);
        run_txn(32'h1c000200, 5'b00000, 1'b1, 1'b0, 1'b0, 32'h1c008000, 32'h1c000204, 3);
        gap(1'b1);
        run_txn(32'h1c000300, 5'b00000, 1'b0, 1'b0, 1'b1, 32'h1c009000, 32'h0, 0);
        gap(1'b0);
        run_txn(32'h1c000304, 5'b00000, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 0);

        // Reset while waiting in REDIR.
        gap(1'b0);
        wb_valid = 1'b1; wb_pc = 32'h1c000400; wb_exc = 5'b01000; wb_ertn = 1'b0;
        timer_int = 1'b0; ex_entry = 32'h1c00a000; redirect_ready = 1'b0;
        @(negedge clk);
        wb_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", redirect_valid, 1'b1);
        #2 reset = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1 check("ready_after_midrst", wb_ready, 1'b1);
        check("flush_after_midrst", flush, 1'b0);
        @(negedge clk);

        // Randomized transactions.
        for (int t = 0; t < 150; t++) begin
            gap($urandom_range(0, 3) == 0);
            run_txn($urandom,
                    ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0,
                    1'($urandom),
                    $urandom_range(0, 3) == 0,
                    1'($urandom),
                    $urandom, $urandom,
                    $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
